// File: rtl/reduce_pkg.sv
// reduce_pkg: shared widths, port/direction constants and flit helpers for the
// reduction input path.
package reduce_pkg;

  localparam int FLIT_SIZE = 82;
  localparam int FAN_IN    = 6;
  localparam int PORT_NUM  = FAN_IN;

  localparam logic [2:0] DIR_INJECT = 3'd0;
  localparam logic [2:0] DIR_NORTH  = 3'd1;
  localparam logic [2:0] DIR_EAST   = 3'd2;
  localparam logic [2:0] DIR_SOUTH  = 3'd3;
  localparam logic [2:0] DIR_WEST   = 3'd4;
  localparam logic [2:0] DIR_UP     = 3'd5;
  localparam logic [2:0] DIR_DOWN   = 3'd6;
  localparam logic [2:0] DIR_EJECT  = 3'd7;

  typedef logic [FLIT_SIZE-1:0] flit_t;

  // Extract port idx's flit from the packed per-port input bus.
  function automatic flit_t flit_slice(input logic [FLIT_SIZE*FAN_IN-1:0] bus,
                                       input int unsigned idx);
    return bus[idx*FLIT_SIZE +: FLIT_SIZE];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after
// ptr (modulo N); the caller owns and advances ptr.
module rr_arbiter #(
  parameter int N = 6,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pidx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    pidx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      pidx = sum[IDX_W-1:0];
      if (en && !grant_vld && req[pidx]) begin
        grant_vld   = 1'b1;
        grant[pidx] = 1'b1;
        grant_idx   = pidx;
      end
    end
  end

endmodule

// File: rtl/reduction_input_arbiter.sv
// reduction_input_arbiter: round-robin share of the reduction datapath across
// FAN_IN inputs with a registered output stage. Round mode: REDUCTION_ROUND_EN.
module reduction_input_arbiter #(
  parameter int FAN_IN    = reduce_pkg::FAN_IN,
  parameter int FLIT_SIZE = reduce_pkg::FLIT_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_SIZE*FAN_IN-1:0] in,
  input  logic [FAN_IN-1:0]           in_valid,
  output logic [FAN_IN-1:0]           in_avail,
  output logic [FLIT_SIZE-1:0]        out,
  output logic                        out_valid,
  input  logic                        out_avail,
  output logic                        out_last,
  input  logic [FAN_IN-1:0]           round_mask
);
  import reduce_pkg::*;

  localparam int IDX_W = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;

  logic [IDX_W-1:0]     ptr_q;
  logic [FAN_IN-1:0]    eligible;
  logic [FAN_IN-1:0]    grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic                 can_load;
  logic [FLIT_SIZE-1:0] out_q;
  logic                 out_valid_q;
  logic                 out_last_q;

  assign can_load = !out_valid_q || out_avail;

  rr_arbiter #(.N(FAN_IN)) u_rr_arbiter (
    .req       (eligible),
    .ptr       (ptr_q),
    .en        (can_load && !rst),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign in_avail  = grant;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else if (grant_vld) begin
      out_q       <= flit_slice(in, int'(grant_idx));
      out_valid_q <= 1'b1;
      ptr_q       <= (grant_idx == IDX_W'(FAN_IN-1)) ? '0 : grant_idx + 1'b1;
    end else if (out_avail) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef REDUCTION_ROUND_EN
  logic [FAN_IN-1:0] served_q;
  logic [FAN_IN-1:0] active_mask_q;
  logic [FAN_IN-1:0] round_set;
  logic [FAN_IN-1:0] served_next;
  logic              round_done;

  // The round's membership is sampled from round_mask only until the first
  // grant; after that the latched copy governs the rest of the round.
  assign round_set   = (served_q == '0) ? round_mask : active_mask_q;
  assign eligible    = in_valid & round_set & ~served_q;
  assign served_next = served_q | grant;
  assign round_done  = (served_next == round_set);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_q      <= '0;
      active_mask_q <= '0;
      out_last_q    <= 1'b0;
    end else if (grant_vld) begin
      if (served_q == '0) active_mask_q <= round_mask;
      served_q   <= round_done ? '0 : served_next;
      out_last_q <= round_done;
    end else if (out_avail) begin
      out_last_q <= 1'b0;
    end
  end
`else
  logic unused_round_mask;

  assign unused_round_mask = ^round_mask;
  assign eligible          = in_valid;
  assign out_last_q        = 1'b0;
`endif

endmodule

// File: tb/tb_reduction_input_arbiter.sv
// Self-checking bench for reduction_input_arbiter: directed literal checks plus
// randomized traffic compared against a behavioural model every cycle.
module tb_reduction_input_arbiter;
  localparam int N = 6;
  localparam int W = 82;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W*N-1:0] in_bus;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_avail;
  logic [N-1:0]   round_mask = '1;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_avail = 1'b1;
  logic           out_last;
  logic [W-1:0]   flit [N];

  int vectors = 0;
  int miscompares = 0;
  int checks = 0;

  // behavioural model state
  logic [W-1:0] m_out = '0;
  bit           m_valid = 0;
  bit           m_last = 0;
  int           m_ptr = 0;
  bit           m_served [N];
  bit           m_members [N];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign in_bus[i*W +: W] = flit[i];
  end

  reduction_input_arbiter #(.FAN_IN(N), .FLIT_SIZE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_bus),
    .in_valid   (in_valid),
    .in_avail   (in_avail),
    .out        (out),
    .out_valid  (out_valid),
    .out_avail  (out_avail),
    .out_last   (out_last),
    .round_mask (round_mask)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic new_flits();
    logic [95:0] t;
    for (int i = 0; i < N; i++) begin
      t = {$urandom, $urandom, $urandom};
      flit[i] = t[W-1:0];
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    look();
    tick();
    rst = 1'b0;
  endtask

  // Model: compare current outputs, predict this cycle's grant, then advance.
  always @(negedge clk) begin
    int g;
    int p;
    bit any_srv;
    bit done;
    bit elig;
    logic [N-1:0] exp_av;
    vectors++;
    if (rst) begin
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_last", 128'(out_last), 128'(0));
      check("rst_in_avail", 128'(in_avail), 128'(0));
      check("rst_out", 128'(out), 128'(0));
      m_valid = 0; m_last = 0; m_out = '0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin m_served[i] = 0; m_members[i] = 0; end
    end else begin
      check("out_valid", 128'(out_valid), 128'(m_valid));
      if (m_valid) check("out", 128'(out), 128'(m_out));
`ifdef REDUCTION_ROUND_EN
      if (m_valid) check("out_last", 128'(out_last), 128'(m_last));
`else
      check("out_last_tied", 128'(out_last), 128'(0));
`endif
      any_srv = 0;
      for (int i = 0; i < N; i++) any_srv |= m_served[i];
      g = -1;
      if (!m_valid || out_avail) begin
        for (int k = 0; k < N; k++) begin
          p = (m_ptr + k) % N;
`ifdef REDUCTION_ROUND_EN
          elig = in_valid[p] && !m_served[p] && (any_srv ? m_members[p] : round_mask[p]);
`else
          elig = in_valid[p];
`endif
          if (g < 0 && elig) g = p;
        end
      end
      exp_av = '0;
      if (g >= 0) exp_av[g] = 1'b1;
      check("in_avail", 128'(in_avail), 128'(exp_av));
      if (g >= 0) begin
        m_out = flit[g];
        m_valid = 1;
        m_ptr = (g + 1) % N;
        if (!any_srv) for (int i = 0; i < N; i++) m_members[i] = round_mask[i];
        m_served[g] = 1;
        done = 1;
        for (int i = 0; i < N; i++) if (m_served[i] != m_members[i]) done = 0;
        m_last = done;
        if (done) for (int i = 0; i < N; i++) m_served[i] = 0;
      end else if (out_avail) begin
        m_valid = 0;
        m_last = 0;
      end
    end
  end

  initial begin
    logic [N-1:0] e;
`ifdef REDUCTION_ROUND_EN
    int seq [8] = '{1, 2, 4, 1, 2, 4, 5, 0};
    bit lst [8] = '{0, 0, 1, 0, 0, 1, 0, 1};
`endif
    new_flits();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // idle, then a single port 0 flit
    for (int k = 0; k < 10; k++) begin
      look();
      check("idle_in_avail", 128'(in_avail), 128'(0));
      check("idle_out_valid", 128'(out_valid), 128'(0));
      tick();
    end
    in_valid = 6'b000001;
    look();
    check("first_grant", 128'(in_avail), 128'(6'b000001));
    tick();
    in_valid = '0;
    look();
    check("first_out", 128'(out), 128'(flit[0]));
    check("first_out_valid", 128'(out_valid), 128'(1));

    // all ports valid: 0..5 then wrap to 0
    do_reset();
    in_valid = '1;
    for (int k = 0; k < 7; k++) begin
      look();
      e = '0;
      e[k % N] = 1'b1;
      check("rr_order", 128'(in_avail), 128'(e));
      if (k > 0) begin
        check("rr_out_valid", 128'(out_valid), 128'(1));
        check("rr_out", 128'(out), 128'(flit[(k-1) % N]));
      end
      tick();
    end

    // backpressure holds the output and resumes from the saved pointer
    out_avail = 1'b0;
    for (int k = 0; k < 5; k++) begin
      look();
      check("bp_in_avail", 128'(in_avail), 128'(0));
      check("bp_out", 128'(out), 128'(flit[0]));
      check("bp_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    out_avail = 1'b1;
    look();
    check("bp_resume", 128'(in_avail), 128'(6'b000010));
    tick();

`ifdef REDUCTION_ROUND_EN
    // rounds over mask 010110; mid-round mask change is ignored
    do_reset();
    round_mask = 6'b010110;
    in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      look();
      e = '0;
      e[seq[k]] = 1'b1;
      check("round_grant", 128'(in_avail), 128'(e));
      if (k > 0) begin
        check("round_out", 128'(out), 128'(flit[seq[k-1]]));
        check("round_last", 128'(out_last), 128'(lst[k-1]));
      end
      tick();
      if (k == 3) round_mask = 6'b100001;
    end
    look();
    check("round_out", 128'(out), 128'(flit[0]));
    check("round_last", 128'(out_last), 128'(1));
    tick();
    round_mask = '1;
`endif

    // asynchronous reset mid-stream
    in_valid = '1;
    tick();
    look();
    tick();
    rst = 1'b1;
    #1;
    check("async_out_valid", 128'(out_valid), 128'(0));
    check("async_out_last", 128'(out_last), 128'(0));
    check("async_in_avail", 128'(in_avail), 128'(0));
    in_valid = 6'b001100;
    look();
    tick();
    rst = 1'b0;
    look();
    check("post_rst_grant", 128'(in_avail), 128'(6'b000100));
    tick();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      new_flits();
      in_valid  = N'($urandom);
      out_avail = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) round_mask = N'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    look();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
